// File: rtl/dist_topk_select.sv
// Streaming top-K nearest-neighbour selector: keeps the K smallest distances of a frame
// in a sorted table, then emits them in ascending order through a ready/valid port.
module dist_topk_select #(
  parameter int K      = 4,
  parameter int DIST_W = 7,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIST_W-1:0] in_dist,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DIST_W-1:0] out_dist,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last
);

  localparam int CNT_W = $clog2(K + 1);
  localparam int PTR_W = $clog2(K);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_K   = CNT_W'(K);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [DIST_W-1:0] dist_q [K];
  logic [DIST_W-1:0] dist_d [K];
  logic [IDX_W-1:0]  idx_q  [K];
  logic [IDX_W-1:0]  idx_d  [K];
  logic [K-1:0]      vld_q, vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              in_ready_q;

  logic [K-1:0]      keep;
  logic              accept;
  logic              lastEntry;

  // A slot keeps its entry when it is valid and not larger than the new sample,
  // which places a new sample behind every equal distance already stored.
  always_comb begin
    keep = '0;
    for (int i = 0; i < K; i++) begin
      keep[i] = vld_q[i] && (dist_q[i] <= in_dist);
    end
  end

  assign accept    = in_valid && in_ready_q;
  assign lastEntry = ((CNT_W'(ptr_q) + CNT_ONE) == cnt_q);

  always_comb begin
    state_d = state_q;
    dist_d  = dist_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          vld_d   = '0;
          cnt_d   = '0;
          ptr_d   = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          if (!keep[0]) begin
            dist_d[0] = in_dist;
            idx_d[0]  = in_idx;
            vld_d[0]  = 1'b1;
          end
          // Slots past the insertion point take their upper neighbour; a full table
          // whose last slot is kept leaves the sample with nowhere to go.
          for (int i = 1; i < K; i++) begin
            if (!keep[i]) begin
              if (keep[i-1]) begin
                dist_d[i] = in_dist;
                idx_d[i]  = in_idx;
                vld_d[i]  = 1'b1;
              end else begin
                dist_d[i] = dist_q[i-1];
                idx_d[i]  = idx_q[i-1];
                vld_d[i]  = vld_q[i-1];
              end
            end
          end
          if (cnt_q != CNT_K) begin
            cnt_d = cnt_q + CNT_ONE;
          end
          if (in_last) begin
            ptr_d   = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (lastEntry) begin
            state_d = IDLE;
          end else begin
            ptr_d = ptr_q + PTR_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      vld_q      <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      in_ready_q <= 1'b0;
      for (int i = 0; i < K; i++) begin
        dist_q[i] <= '0;
        idx_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      vld_q      <= vld_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      in_ready_q <= (state_d == COLLECT);
      for (int i = 0; i < K; i++) begin
        dist_q[i] <= dist_d[i];
        idx_q[i]  <= idx_d[i];
      end
    end
  end

  // The table is frozen during DRAIN, so the read mux holds stable under back-pressure.
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == DRAIN);
  assign out_dist  = out_valid ? dist_q[ptr_q] : '0;
  assign out_idx   = out_valid ? idx_q[ptr_q] : '0;
  assign out_last  = out_valid && lastEntry;

endmodule

// File: tb/tb_dist_topk_select.sv
// Directed bench for dist_topk_select: a small sorted-list model fills a scoreboard
// while samples are driven; the drain phase pops and compares each emitted entry.
module tb_dist_topk_select;

  localparam int K      = 4;
  localparam int DIST_W = 7;
  localparam int IDX_W  = 8;

  typedef struct packed {
    logic [DIST_W-1:0] d;
    logic [IDX_W-1:0]  i;
  } ent_t;

  typedef struct packed {
    logic [DIST_W-1:0] d;
    logic [IDX_W-1:0]  i;
    logic              last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DIST_W-1:0] in_dist;
  logic [IDX_W-1:0]  in_idx;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DIST_W-1:0] out_dist;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;

  int   checkCount = 0;
  int   passCount  = 0;
  int   failCount  = 0;
  ent_t model[$];
  exp_t expQ[$];

  dist_topk_select #(.K(K), .DIST_W(DIST_W), .IDX_W(IDX_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_dist  (in_dist),
    .in_idx   (in_idx),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_dist (out_dist),
    .out_idx  (out_idx),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startFrame();
    start = 1'b1;
    tick();
    start = 1'b0;
    model.delete();
  endtask

  // Drives one sample for one cycle and updates the reference list; the final sample
  // of a frame moves the whole list into the scoreboard.
  task automatic applyStimulus(input logic [DIST_W-1:0] d, input logic [IDX_W-1:0] i,
                               input logic last);
    ent_t e;
    int   pos;
    in_valid = 1'b1;
    in_dist  = d;
    in_idx   = i;
    in_last  = last;
    @(negedge clk);
    checkOutput("inReady", 32'(in_ready), 32'd1);
    e.d = d;
    e.i = i;
    pos = model.size();
    for (int j = 0; j < model.size(); j++) begin
      if (model[j].d > d) begin
        pos = j;
        break;
      end
    end
    if (pos == model.size()) model.push_back(e);
    else model.insert(pos, e);
    if (model.size() > K) void'(model.pop_back());
    if (last) begin
      for (int j = 0; j < model.size(); j++) begin
        exp_t x;
        x.d    = model[j].d;
        x.i    = model[j].i;
        x.last = (j == model.size() - 1);
        expQ.push_back(x);
      end
      model.delete();
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // stallMode 0: out_ready always 1; stallMode 1: out_ready pattern 1,0,0 repeating.
  task automatic drainFrame(input int stallMode);
    int                cyc  = 0;
    bit                held = 1'b0;
    logic [DIST_W-1:0] hDist;
    logic [IDX_W-1:0]  hIdx;
    logic              hLast;
    exp_t              x;
    while (expQ.size() > 0 && cyc < 200) begin
      out_ready = (stallMode == 0) ? 1'b1 : ((cyc % 3) == 0);
      @(negedge clk);
      if (cyc == 0) checkOutput("outValidRise", 32'(out_valid), 32'd1);
      if (out_valid) begin
        if (held) begin
          checkOutput("holdDist", 32'(out_dist), 32'(hDist));
          checkOutput("holdIdx", 32'(out_idx), 32'(hIdx));
          checkOutput("holdLast", 32'(out_last), 32'(hLast));
        end
        if (out_ready) begin
          x = expQ.pop_front();
          checkOutput("outDist", 32'(out_dist), 32'(x.d));
          checkOutput("outIdx", 32'(out_idx), 32'(x.i));
          checkOutput("outLast", 32'(out_last), 32'(x.last));
          held = 1'b0;
        end else begin
          hDist = out_dist;
          hIdx  = out_idx;
          hLast = out_last;
          held  = 1'b1;
        end
      end
      tick();
      cyc++;
    end
    checkOutput("drainPending", 32'(expQ.size()), 32'd0);
    expQ.delete();
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("idleOutValid", 32'(out_valid), 32'd0);
    checkOutput("idleInReady", 32'(in_ready), 32'd0);
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_dist   = '0;
    in_idx    = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #3;
    checkOutput("rstInReady", 32'(in_ready), 32'd0);
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstOutLast", 32'(out_last), 32'd0);
    checkOutput("rstOutDist", 32'(out_dist), 32'd0);
    checkOutput("rstOutIdx", 32'(out_idx), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Samples offered while idle must be ignored.
    $display("[TB] idle samples without start");
    in_valid = 1'b1;
    in_dist  = 7'd5;
    in_idx   = 8'd1;
    in_last  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("idleNoReady", 32'(in_ready), 32'd0);
      checkOutput("idleNoOut", 32'(out_valid), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    $display("[TB] basic frame");
    startFrame();
    applyStimulus(7'd9, 8'd0, 1'b0);
    applyStimulus(7'd3, 8'd1, 1'b0);
    applyStimulus(7'd40, 8'd2, 1'b0);
    applyStimulus(7'd3, 8'd3, 1'b0);
    applyStimulus(7'd0, 8'd4, 1'b0);
    applyStimulus(7'd12, 8'd5, 1'b1);
    drainFrame(0);

    $display("[TB] single-sample frame");
    startFrame();
    applyStimulus(7'd5, 8'd7, 1'b1);
    drainFrame(0);

    $display("[TB] basic frame with back-pressure");
    startFrame();
    applyStimulus(7'd9, 8'd0, 1'b0);
    applyStimulus(7'd3, 8'd1, 1'b0);
    applyStimulus(7'd40, 8'd2, 1'b0);
    applyStimulus(7'd3, 8'd3, 1'b0);
    applyStimulus(7'd0, 8'd4, 1'b0);
    applyStimulus(7'd12, 8'd5, 1'b1);
    drainFrame(1);

    $display("[TB] full-table drop and tie insertion");
    startFrame();
    applyStimulus(7'd1, 8'd0, 1'b0);
    applyStimulus(7'd2, 8'd1, 1'b0);
    applyStimulus(7'd3, 8'd2, 1'b0);
    applyStimulus(7'd4, 8'd3, 1'b0);
    applyStimulus(7'd4, 8'd9, 1'b0);
    applyStimulus(7'd2, 8'd8, 1'b1);
    drainFrame(0);

    $display("[TB] start ignored mid-collect");
    startFrame();
    applyStimulus(7'd10, 8'd1, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    checkOutput("collectReadyAfterStart", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(7'd4, 8'd2, 1'b1);
    drainFrame(0);

    $display("[TB] full-width distances");
    startFrame();
    applyStimulus(7'd127, 8'd1, 1'b0);
    applyStimulus(7'd0, 8'd2, 1'b0);
    applyStimulus(7'd127, 8'd3, 1'b0);
    applyStimulus(7'd64, 8'd4, 1'b0);
    for (int j = 0; j < 8; j++) begin
      applyStimulus(7'($urandom_range(0, 127)), 8'(j + 20), (j == 7));
    end
    drainFrame(1);

    $display("[TB] reset during drain");
    startFrame();
    applyStimulus(7'd20, 8'd1, 1'b0);
    applyStimulus(7'd15, 8'd2, 1'b0);
    applyStimulus(7'd30, 8'd3, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("abortFirstDist", 32'(out_dist), 32'd15);
    tick();
    @(negedge clk);
    checkOutput("abortSecondDist", 32'(out_dist), 32'd20);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abortOutValid", 32'(out_valid), 32'd0);
    checkOutput("abortInReady", 32'(in_ready), 32'd0);
    checkOutput("abortOutDist", 32'(out_dist), 32'd0);
    checkOutput("abortOutIdx", 32'(out_idx), 32'd0);
    checkOutput("abortOutLast", 32'(out_last), 32'd0);
    expQ.delete();
    tick();
    rst      = 1'b0;
    start    = 1'b1;
    in_valid = 1'b1;
    in_dist  = 7'd50;
    in_idx   = 8'd99;
    in_last  = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    model.delete();
    applyStimulus(7'd8, 8'd4, 1'b0);
    applyStimulus(7'd6, 8'd5, 1'b1);
    drainFrame(0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
